i2c_slave_regfile: RTL and testbench

// - Parametrised I2C slave with an internal byte register file; successor to the fixed-address, fixed-data slave.
// - Oversamples SCL/SDA on clk and detects START, repeated START and STOP.
// - Supports write (pointer + auto-increment burst), read burst and a host-side register port.
// - Sits between the open-drain pad cells and the local control logic.

---
 rtl/i2c_slave_regfile.sv | 204 ++++++++++++++++++++
 tb/tb_i2c_slave_regfile.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_regfile.sv
// I2C slave with a byte register file, auto-increment pointer and host port.
// Define I2C_GEN_CALL_EN to also ACK the general-call address (7'h00, write).
module i2c_slave_regfile #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h55,
  parameter int         NUM_REGS    = 16,
  parameter int         SYNC_STAGES = 2,
  localparam int        AW          = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          scl_i,
  input  logic          sda_i,
  output logic          sda_oe,
  input  logic [AW-1:0] host_addr,
  input  logic          host_we,
  input  logic [7:0]    host_wdata,
  output logic [7:0]    host_rdata,
  output logic          wr_valid,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic          busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK,
    RDATA, RACK, WAIT_STOP, GC_DATA, GC_ACK
  } state_t;

  localparam logic [AW-1:0] LAST = AW'(NUM_REGS - 1);

  logic [SYNC_STAGES-1:0] scl_q, sda_q;
  logic          scl_s, sda_s, scl_p, sda_p;
  logic          scl_rise, scl_fall, start, stop;
  state_t        state, state_n;
  logic [3:0]    cnt, cnt_n;
  logic [7:0]    shreg, rbuf;
  logic [AW-1:0] ptr, ptr_inc;
  logic          mack, oe_n;
  logic          hit, gc, ptr_ok, done, rx;
  logic          ld_ptr, inc_ptr, do_wr, ld_rbuf, set_busy;
  logic [7:0]    regs [NUM_REGS];

  assign scl_s    = scl_q[SYNC_STAGES-1];
  assign sda_s    = sda_q[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_p;
  assign scl_fall = ~scl_s & scl_p;
  assign start    = scl_s & scl_p & sda_p & ~sda_s;
  assign stop     = scl_s & scl_p & ~sda_p & sda_s;

  // cnt runs 7..0 on SCL rises; bit 3 set means all 8 bits are in
  assign done    = cnt[3];
  assign rx      = state inside {ADDR, PTR, WDATA, GC_DATA};
  assign hit     = shreg[7:1] == SLAVE_ADDR;
  assign ptr_ok  = {1'b0, shreg} < 9'(NUM_REGS);
  assign ptr_inc = (ptr == LAST) ? '0 : ptr + 1'b1;
`ifdef I2C_GEN_CALL_EN
  assign gc = shreg == 8'h00;
`else
  assign gc = 1'b0;
`endif

  assign host_rdata = regs[host_addr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_q <= '1;
      sda_q <= '1;
      scl_p <= 1'b1;
      sda_p <= 1'b1;
    end else begin
      scl_q <= {scl_q[SYNC_STAGES-2:0], scl_i};
      sda_q <= {sda_q[SYNC_STAGES-2:0], sda_i};
      scl_p <= scl_s;
      sda_p <= sda_s;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    ld_ptr   = 1'b0;
    inc_ptr  = 1'b0;
    do_wr    = 1'b0;
    ld_rbuf  = 1'b0;
    set_busy = 1'b0;
    unique case (1'b1)
      start: begin
        state_n = ADDR;
        cnt_n   = 4'd7;
      end
      stop: state_n = IDLE;
      scl_rise: if (rx) cnt_n = cnt - 4'd1;
      scl_fall: begin
        unique case (state)
          ADDR: if (done) begin
            if (hit || gc) begin
              state_n  = ADDR_ACK;
              set_busy = 1'b1;
            end else begin
              state_n = WAIT_STOP;
            end
          end
          ADDR_ACK: begin
            cnt_n = 4'd7;
            if (gc) begin
              state_n = GC_DATA;
            end else if (shreg[0]) begin
              state_n = RDATA;
              ld_rbuf = 1'b1;
            end else begin
              state_n = PTR;
            end
          end
          PTR: if (done) begin
            state_n = ptr_ok ? PTR_ACK : WAIT_STOP;
            ld_ptr  = ptr_ok;
          end
          PTR_ACK, WDATA_ACK: begin
            state_n = WDATA;
            cnt_n   = 4'd7;
          end
          WDATA: if (done) begin
            state_n = WDATA_ACK;
            do_wr   = 1'b1;
            inc_ptr = 1'b1;
          end
          RDATA: begin
            if (cnt == 4'd0) begin
              state_n = RACK;
              inc_ptr = 1'b1;
            end else begin
              cnt_n = cnt - 4'd1;
            end
          end
          RACK: begin
            cnt_n = 4'd7;
            if (mack) begin
              state_n = WAIT_STOP;
            end else begin
              state_n = RDATA;
              ld_rbuf = 1'b1;
            end
          end
          GC_DATA: if (done) state_n = GC_ACK;
          GC_ACK:  state_n = WAIT_STOP;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_comb begin
    oe_n = 1'b0;
    unique case (state)
      ADDR_ACK, PTR_ACK, WDATA_ACK, GC_ACK: oe_n = 1'b1;
      RDATA:   oe_n = ~rbuf[cnt[2:0]];
      default: oe_n = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= 4'd7;
      shreg    <= '0;
      rbuf     <= '0;
      ptr      <= '0;
      mack     <= 1'b0;
      busy     <= 1'b0;
      sda_oe   <= 1'b0;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      sda_oe   <= oe_n;
      wr_valid <= do_wr;
      if (scl_rise && rx) shreg <= {shreg[6:0], sda_s};
      if (scl_rise && state == RACK) mack <= sda_s;
      if (ld_rbuf) rbuf <= regs[ptr];
      if (ld_ptr) ptr <= shreg[AW-1:0];
      else if (inc_ptr) ptr <= ptr_inc;
      if (stop) busy <= 1'b0;
      else if (set_busy) busy <= 1'b1;
      if (do_wr) begin
        wr_addr <= ptr;
        wr_data <= shreg;
      end
    end
  end

  // the I2C write is applied last so it wins a same-index host write
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      if (host_we) regs[host_addr] <= host_wdata;
      if (do_wr) regs[ptr] <= shreg;
    end
  end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Bench for i2c_slave_regfile: bit-banged master, register model, write scoreboard.
module tb_i2c_slave_regfile;
  localparam int NR   = 16;
  localparam int AW   = 4;
  localparam int SYNC = 2;
  localparam int Q    = 8;

  typedef struct {
    int         a;
    logic [7:0] d;
  } wr_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          scl_m = 1'b1;
  logic          sda_m = 1'b1;
  logic          sda_line;
  logic          sda_oe, wr_valid, busy;
  logic [AW-1:0] host_addr = '0;
  logic [AW-1:0] wr_addr;
  logic          host_we = 1'b0;
  logic [7:0]    host_wdata = '0;
  logic [7:0]    host_rdata, wr_data;

  int         total = 0;
  int         bad = 0;
  logic [7:0] mregs [NR];
  int         mptr = 0;
  wr_t        wrq [$];
  logic [7:0] fixed [$];
  bit         oe_seen = 1'b0;

  assign sda_line = sda_m & ~sda_oe;

  i2c_slave_regfile #(
    .SLAVE_ADDR (7'h55),
    .NUM_REGS   (NR),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .scl_i     (scl_m),
    .sda_i     (sda_line),
    .sda_oe    (sda_oe),
    .host_addr (host_addr),
    .host_we   (host_we),
    .host_wdata(host_wdata),
    .host_rdata(host_rdata),
    .wr_valid  (wr_valid),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // write monitor: every wr_valid pulse must match the oldest expected write
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (sda_oe) oe_seen = 1'b1;
      if (wr_valid) begin
        total++;
        if (wrq.size() == 0) begin
          bad++;
          $display("FAIL wr_unexpected: got addr %0h data %0h want none",
                   wr_addr, wr_data);
        end else begin
          e = wrq.pop_front();
          if (wr_addr !== AW'(e.a) || wr_data !== e.d) begin
            bad++;
            $display("FAIL wr_pulse: got %0h/%0h want %0h/%0h",
                     wr_addr, wr_data, e.a, e.d);
          end
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic q_wait();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; q_wait();
    scl_m = 1'b1; q_wait();
    sda_m = 1'b0; q_wait();
    scl_m = 1'b0; q_wait();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; q_wait();
    scl_m = 1'b1; q_wait();
    sda_m = 1'b1; q_wait();
  endtask

  // hc: pulse host_we on the clock where the slave commits the byte
  task automatic clk_bit(input logic b, input bit hc, output logic s);
    sda_m = b; q_wait();
    scl_m = 1'b1; q_wait();
    s = sda_line; q_wait();
    scl_m = 1'b0;
    if (hc) begin
      repeat (SYNC) @(negedge clk);
      host_we = 1'b1;
      @(negedge clk);
      host_we = 1'b0;
      repeat (Q - SYNC - 1) @(negedge clk);
    end else begin
      q_wait();
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit hc,
                           output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], hc && i == 0, s);
    clk_bit(1'b1, 1'b0, ack);
  endtask

  task automatic recv_byte(input logic ma, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, 1'b0, s);
      d[i] = s;
    end
    clk_bit(ma, 1'b0, s);
  endtask

  task automatic host_write(input int a, input logic [7:0] d);
    host_addr  = AW'(a);
    host_wdata = d;
    host_we    = 1'b1;
    @(negedge clk);
    host_we    = 1'b0;
    mregs[a]   = d;
  endtask

  task automatic sweep();
    for (int i = 0; i < NR; i++) begin
      host_addr = AW'(i);
      @(negedge clk);
      chk($sformatf("host_rdata[%0d]", i), host_rdata, mregs[i]);
    end
  endtask

  // hmode: 0 none, 1 host write same index as first data byte, 2 other index
  task automatic wr_txn(input logic [6:0] a, input logic [7:0] p,
                        input int n, input int hmode);
    logic ack;
    logic [7:0] d;
    bit hit, gc, live, hc;
    hit = (a == 7'h55);
    gc  = 1'b0;
`ifdef I2C_GEN_CALL_EN
    gc  = (a == 7'h00);
`endif
    oe_seen = 1'b0;
    i2c_start();
    send_byte({a, 1'b0}, 1'b0, ack);
    chk("addr_ack", ack, !(hit || gc));
    chk("busy_addr", busy, hit || gc);
    live = hit && (p < NR);
    send_byte(p, 1'b0, ack);
    chk("ptr_ack", ack, !(live || gc));
    if (live) mptr = p;
    for (int i = 0; i < n; i++) begin
      d  = (fixed.size() != 0) ? fixed.pop_front() : 8'($urandom);
      hc = 1'b0;
      if (live && i == 0 && hmode != 0) begin
        hc = 1'b1;
        host_addr  = (hmode == 1) ? AW'(mptr) : AW'((mptr + 5) % NR);
        host_wdata = 8'($urandom);
        mregs[host_addr] = host_wdata;
      end
      if (live) begin
        wrq.push_back('{mptr, d});
        mregs[mptr] = d;
        mptr = (mptr + 1) % NR;
      end
      send_byte(d, hc, ack);
      chk("data_ack", ack, !live);
    end
    i2c_stop();
    chk("busy_stop", busy, 1'b0);
    if (!(hit || gc)) chk("oe_never", oe_seen, 1'b0);
  endtask

  task automatic rd_body(input int n);
    logic ack;
    logic [7:0] d;
    i2c_start();
    send_byte(8'hAB, 1'b0, ack);
    chk("rd_addr_ack", ack, 1'b0);
    chk("busy_rd", busy, 1'b1);
    for (int i = 0; i < n; i++) begin
      recv_byte(i == n - 1, d);
      chk($sformatf("rd_data[%0d]", mptr), d, mregs[mptr]);
      mptr = (mptr + 1) % NR;
    end
    i2c_stop();
    chk("busy_rd_stop", busy, 1'b0);
  endtask

  task automatic rd_txn(input int p, input int n);
    logic ack;
    i2c_start();
    send_byte(8'hAA, 1'b0, ack);
    chk("rdp_addr_ack", ack, 1'b0);
    send_byte(8'(p), 1'b0, ack);
    chk("rdp_ptr_ack", ack, 1'b0);
    mptr = p;
    rd_body(n);
  endtask

  initial begin
    logic ack, s;
    for (int i = 0; i < NR; i++) mregs[i] = '0;
    repeat (4) @(negedge clk);
    chk("rst_sda_oe", sda_oe, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_wr_valid", wr_valid, 1'b0);
    chk("rst_wr_addr", wr_addr, '0);
    chk("rst_wr_data", wr_data, '0);
    sweep();
    reset = 1'b1;
    repeat (4) @(negedge clk);

    fixed = '{8'h11, 8'h22};
    wr_txn(7'h55, 8'h02, 2, 0);
    chk("wrq_empty_1", wrq.size(), 0);
    sweep();

    wr_txn(7'h23, 8'h02, 2, 0);
    wr_txn(7'h55, 8'h05, 1, 0);

    fixed = '{8'h5A, 8'hA5};
    wr_txn(7'h55, 8'h0F, 2, 0);
    rd_body(1);

    rd_txn(4, 3);
    wr_txn(7'h55, 8'h20, 1, 0);
    wr_txn(7'h00, 8'h03, 1, 0);
    wr_txn(7'h55, 8'h08, 2, 1);
    wr_txn(7'h55, 8'h0A, 1, 2);
    sweep();

    for (int k = 0; k < 5; k++) begin
      host_write($urandom_range(0, NR - 1), 8'($urandom));
      wr_txn(7'h55, 8'($urandom_range(0, 19)), $urandom_range(1, 3),
             $urandom_range(0, 2));
      rd_txn($urandom_range(0, NR - 1), $urandom_range(1, 3));
      sweep();
    end

    // STOP in the middle of a data byte
    i2c_start();
    send_byte(8'hAA, 1'b0, ack);
    chk("abort_addr_ack", ack, 1'b0);
    send_byte(8'h09, 1'b0, ack);
    chk("abort_ptr_ack", ack, 1'b0);
    mptr = 9;
    for (int i = 0; i < 4; i++) clk_bit(1'($urandom), 1'b0, s);
    i2c_stop();
    chk("abort_busy", busy, 1'b0);
    sweep();

    // reset in the middle of a read of a zero byte (slave pulling SDA)
    host_write(7, 8'h00);
    i2c_start();
    send_byte(8'hAA, 1'b0, ack);
    send_byte(8'h07, 1'b0, ack);
    i2c_start();
    send_byte(8'hAB, 1'b0, ack);
    chk("mid_rd_ack", ack, 1'b0);
    for (int i = 0; i < 4; i++) begin
      clk_bit(1'b1, 1'b0, s);
      chk("mid_rd_bit", s, 1'b0);
    end
    chk("oe_pre_reset", sda_oe, 1'b1);
    reset = 1'b0;
    #1;
    chk("oe_async", sda_oe, 1'b0);
    chk("rst2_busy", busy, 1'b0);
    chk("rst2_wr_valid", wr_valid, 1'b0);
    chk("rst2_wr_addr", wr_addr, '0);
    chk("rst2_wr_data", wr_data, '0);
    for (int i = 0; i < NR; i++) mregs[i] = '0;
    mptr = 0;
    scl_m = 1'b1;
    sda_m = 1'b1;
    repeat (4) @(negedge clk);
    sweep();
    reset = 1'b1;
    repeat (4) @(negedge clk);
    host_write(0, 8'h3C);
    host_write(1, 8'hC3);
    rd_body(2);
    chk("wrq_empty_end", wrq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
